// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns execute-stage requests into doubleword data_memory
// accesses, using read-modify-write for narrow stores and sign/zero extension for loads.
module load_store_unit #(
   parameter int MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   output logic [63:0] resp_data,
   output logic [4:0]  resp_rd,
   output logic        resp_fault,
   output logic        mem_read,
   output logic        mem_write,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

   localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);

   state_e      state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [2:0]  offset_q, offset_d;
   logic [63:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        resp_valid_q, resp_valid_d;
   logic [63:0] resp_data_q, resp_data_d;
   logic [4:0]  resp_rd_q, resp_rd_d;
   logic        resp_fault_q, resp_fault_d;
   logic        mem_read_q, mem_read_d;
   logic        mem_write_q, mem_write_d;
   logic [63:0] mem_addr_q, mem_addr_d;
   logic [63:0] mem_wdata_q, mem_wdata_d;

   logic        accept;
   logic        misaligned;
   logic        req_fault;
   logic [5:0]  shamt;
   logic [63:0] lane;
   logic [63:0] load_ext;
   logic [63:0] base_mask;
   logic [63:0] lane_mask;
   logic [63:0] merged;

   assign req_ready  = (state_q == IDLE) && !rst;
   assign accept     = req_valid && req_ready;

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_data_q;
   assign resp_rd    = resp_rd_q;
   assign resp_fault = resp_fault_q;
   assign mem_read   = mem_read_q;
   // NOTE: the write strobe is registered, so reset must also gate it combinationally
   // or a reset landing in WRITE would still commit the store at that edge.
   assign mem_write  = mem_write_q && !rst;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;

   always_comb begin
      case (req_funct3[1:0])
         2'b01:   misaligned = req_addr[0];
         2'b10:   misaligned = |req_addr[1:0];
         2'b11:   misaligned = |req_addr[2:0];
         default: misaligned = 1'b0;
      endcase
      req_fault = misaligned || (req_addr >= MEM_LIMIT) ||
                  (req_is_store ? req_funct3[2] : (req_funct3 == 3'b111));
   end

   // Lane extraction for loads and byte-lane merge for narrow stores.
   always_comb begin
      shamt = {offset_q, 3'b000};
      lane  = mem_rdata >> shamt;
      case (funct3_q)
         3'b000:  load_ext = {{56{lane[7]}}, lane[7:0]};
         3'b001:  load_ext = {{48{lane[15]}}, lane[15:0]};
         3'b010:  load_ext = {{32{lane[31]}}, lane[31:0]};
         3'b011:  load_ext = lane;
         3'b100:  load_ext = {56'd0, lane[7:0]};
         3'b101:  load_ext = {48'd0, lane[15:0]};
         3'b110:  load_ext = {32'd0, lane[31:0]};
         default: load_ext = '0;
      endcase
      case (funct3_q[1:0])
         2'b00:   base_mask = 64'h0000_0000_0000_00FF;
         2'b01:   base_mask = 64'h0000_0000_0000_FFFF;
         2'b10:   base_mask = 64'h0000_0000_FFFF_FFFF;
         default: base_mask = '1;
      endcase
      lane_mask = base_mask << shamt;
      merged    = (mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
   end

   always_comb begin
      // NOTE: every _d gets a default here so no path through the case infers a latch.
      state_d      = state_q;
      funct3_d     = funct3_q;
      offset_d     = offset_q;
      wdata_d      = wdata_q;
      rd_d         = rd_q;
      resp_valid_d = 1'b0;
      resp_data_d  = '0;
      resp_rd_d    = resp_rd_q;
      resp_fault_d = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               funct3_d = req_funct3;
               offset_d = req_addr[2:0];
               wdata_d  = req_wdata;
               rd_d     = req_rd;
               if (req_fault) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_fault_d = 1'b1;
                  resp_rd_d    = req_rd;
               end else begin
                  mem_addr_d = {req_addr[63:3], 3'b000};
                  if (!req_is_store) begin
                     state_d    = LOAD;
                     mem_read_d = 1'b1;
                  end else if (req_funct3[1:0] == 2'b11) begin
                     state_d     = WRITE;
                     mem_write_d = 1'b1;
                     mem_wdata_d = req_wdata;
                  end else begin
                     state_d    = RMW_RD;
                     mem_read_d = 1'b1;
                  end
               end
            end
         end
         LOAD: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_data_d  = load_ext;
            resp_rd_d    = rd_q;
         end
         RMW_RD: begin
            state_d     = WRITE;
            mem_write_d = 1'b1;
            mem_wdata_d = merged;
         end
         WRITE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rd_d    = rd_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples
   // the same pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         funct3_q     <= '0;
         offset_q     <= '0;
         wdata_q      <= '0;
         rd_q         <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_rd_q    <= '0;
         resp_fault_q <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         funct3_q     <= funct3_d;
         offset_q     <= offset_d;
         wdata_q      <= wdata_d;
         rd_q         <= rd_d;
         resp_valid_q <= resp_valid_d;
         resp_data_q  <= resp_data_d;
         resp_rd_q    <= resp_rd_d;
         resp_fault_q <= resp_fault_d;
         mem_read_q   <= mem_read_d;
         mem_write_q  <= mem_write_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic,
// compared against a byte-array reference model of memory and the access rules.
module tb_load_store_unit;

   localparam int MEM_BYTES = 1024;
   localparam int MEM_DWS   = MEM_BYTES / 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [63:0] req_addr = '0;
   logic [63:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        resp_valid;
   logic [63:0] resp_data;
   logic [4:0]  resp_rd;
   logic        resp_fault;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   logic [63:0] dmem    [MEM_DWS];
   logic [7:0]  ref_mem [MEM_BYTES];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_is_store (req_is_store),
      .req_funct3   (req_funct3),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_rd       (req_rd),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .resp_rd      (resp_rd),
      .resp_fault   (resp_fault),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   // data_memory: combinational read, write on the rising edge.
   assign mem_rdata = (mem_addr < 64'(MEM_BYTES)) ? dmem[mem_addr[9:3]] : '0;
   always @(posedge clk) begin
      if (mem_write && (mem_addr < 64'(MEM_BYTES))) dmem[mem_addr[9:3]] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: applies the access rules to a flat byte array.
   task automatic model(input bit st, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output bit flt, output logic [63:0] data,
                        output int lat, output int nrd, output int nwr);
      int size;
      int base;
      logic [63:0] v;
      logic [63:0] ones;
      size = 1 << f3[1:0];
      ones = '1;
      flt  = ((a % 64'(size)) != 0) || (a >= 64'(MEM_BYTES)) ||
             (!st && f3 == 3'd7) || (st && f3 > 3'd3);
      data = '0;
      if (flt) begin
         lat = 1; nrd = 0; nwr = 0;
      end else if (st) begin
         base = int'(a[9:0]);
         for (int i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
         lat = (size == 8) ? 2 : 3;
         nrd = (size == 8) ? 0 : 1;
         nwr = 1;
      end else begin
         base = int'(a[9:0]);
         v = '0;
         for (int i = 0; i < size; i++) v = v | (64'(ref_mem[base + i]) << (8*i));
         if (!f3[2] && size < 8 && v[8*size-1]) v = v | (ones << (8*size));
         data = v;
         lat = 2; nrd = 1; nwr = 0;
      end
   endtask

   task automatic do_txn(input bit st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [4:0] rd,
                         output logic [63:0] got, output logic got_fault);
      bit          eflt;
      logic [63:0] edata;
      int          elat, erd, ewr;
      int          lat, nrd, nwr, both, bad_addr;
      bit          acc, seen;
      logic [4:0]  grd;
      lat = 0; nrd = 0; nwr = 0; both = 0; bad_addr = 0;
      acc = 1'b0; seen = 1'b0; got = '0; got_fault = 1'b0; grd = '0;
      @(negedge clk);
      req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
      req_addr = a; req_wdata = wd; req_rd = rd;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (req_ready) acc = 1'b1;
         else @(negedge clk);
      end
      check("accept", 64'(acc), 64'd1);
      model(st, f3, a, wd, eflt, edata, elat, erd, ewr);
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge clk);
         lat++;
         if (mem_read) nrd++;
         if (mem_write) nwr++;
         if (mem_read && mem_write) both++;
         if ((mem_read || mem_write) && mem_addr != {a[63:3], 3'b000}) bad_addr++;
         if (resp_valid) begin
            seen = 1'b1; got = resp_data; got_fault = resp_fault; grd = resp_rd;
         end
      end
      check("resp_seen", 64'(seen), 64'd1);
      check("latency", 64'(lat), 64'(elat));
      check("fault", 64'(got_fault), 64'(eflt));
      check("data", got, edata);
      check("rd_echo", 64'(grd), 64'(rd));
      check("read_cycles", 64'(nrd), 64'(erd));
      check("write_cycles", 64'(nwr), 64'(ewr));
      check("rd_wr_overlap", 64'(both), 64'd0);
      check("mem_addr", 64'(bad_addr), 64'd0);
      @(negedge clk);
      check("resp_pulse", 64'(resp_valid), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [63:0] got;
      logic        gf;
      logic [63:0] d0, d1, exp_dw, a;
      int          acc, nresp, a1, a2, r1, cnt;
      bit          took, st;
      logic [2:0]  f3;
      int          sel;

      for (int b = 0; b < MEM_BYTES; b++) ref_mem[b] = 8'($urandom);
      ref_mem[0] = 8'd5;
      for (int b = 1; b < 8; b++) ref_mem[b] = 8'd0;
      for (int w = 0; w < MEM_DWS; w++)
         for (int b = 0; b < 8; b++) dmem[w][8*b +: 8] = ref_mem[8*w + b];

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_data", resp_data, 64'd0);
      check("rst_resp_rd", 64'(resp_rd), 64'd0);
      check("rst_resp_fault", 64'(resp_fault), 64'd0);
      check("rst_mem_read", 64'(mem_read), 64'd0);
      check("rst_mem_write", 64'(mem_write), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_wdata", mem_wdata, 64'd0);
      rst = 1'b0;

      // 1: LD 0
      do_txn(1'b0, 3'b011, 64'd0, 64'd0, 5'd7, got, gf);
      check("t1_ld0", got, 64'd5);

      // 2: SD 99 @32, LD 32
      do_txn(1'b1, 3'b011, 64'd32, 64'd99, 5'd1, got, gf);
      check("t2_sd_data", got, 64'd0);
      do_txn(1'b0, 3'b011, 64'd32, 64'd0, 5'd2, got, gf);
      check("t2_ld", got, 64'd99);

      // 3: read-modify-write of one byte
      do_txn(1'b1, 3'b011, 64'd64, 64'h0000_0000_0000_00FF, 5'd3, got, gf);
      do_txn(1'b1, 3'b000, 64'h41, 64'h80, 5'd4, got, gf);
      do_txn(1'b0, 3'b011, 64'd64, 64'd0, 5'd5, got, gf);
      check("t3_ld", got, 64'h0000_0000_0000_80FF);
      do_txn(1'b0, 3'b000, 64'h41, 64'd0, 5'd6, got, gf);
      check("t3_lb", got, 64'hFFFF_FFFF_FFFF_FF80);
      do_txn(1'b0, 3'b100, 64'h41, 64'd0, 5'd7, got, gf);
      check("t3_lbu", got, 64'h0000_0000_0000_0080);

      // 4: faults and a legal word load
      do_txn(1'b1, 3'b001, 64'h43, 64'h1234, 5'd8, got, gf);
      check("t4_sh_mis", 64'(gf), 64'd1);
      do_txn(1'b0, 3'b011, 64'd1024, 64'd0, 5'd9, got, gf);
      check("t4_ld_oor", 64'(gf), 64'd1);
      do_txn(1'b0, 3'b111, 64'd0, 64'd0, 5'd10, got, gf);
      check("t4_ld_f7", 64'(gf), 64'd1);
      do_txn(1'b0, 3'b010, 64'h44, 64'd0, 5'd11, got, gf);
      check("t4_lw_ok", 64'(gf), 64'd0);

      // 5: two loads presented with req_valid held high
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011;
      req_addr = 64'd32; req_rd = 5'd12;
      acc = 0; nresp = 0; a1 = -1; a2 = -1; r1 = -1; d0 = '0; d1 = '0;
      for (int c = 0; c < 14; c++) begin
         took = req_valid && req_ready;
         if (resp_valid) begin
            if (nresp == 0) begin d0 = resp_data; r1 = c; end
            else if (nresp == 1) d1 = resp_data;
            nresp++;
         end
         if (took) begin
            acc++;
            if (acc == 1) a1 = c; else a2 = c;
         end
         @(posedge clk);
         #1;
         if (took) begin
            if (acc == 1) req_addr = 64'd64;
            else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      check("t5_accepts", 64'(acc), 64'd2);
      check("t5_resps", 64'(nresp), 64'd2);
      check("t5_d0", d0, 64'd99);
      check("t5_d1", d1, 64'h80FF);
      check("t5_gap", 64'(a2 - a1), 64'd3);
      check("t5_lat", 64'(r1 - a1), 64'd2);

      // 6: reset during WRITE aborts the store
      do_txn(1'b1, 3'b011, 64'd8, 64'd3, 5'd13, got, gf);
      @(negedge clk);
      req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'b011;
      req_addr = 64'd8; req_wdata = 64'd7; req_rd = 5'd14;
      check("t6_ready", 64'(req_ready), 64'd1);
      @(posedge clk);
      #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("t6_wr_gated", 64'(mem_write), 64'd0);
      check("t6_ready_rst", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) cnt++;
      end
      check("t6_no_resp", 64'(cnt), 64'd0);
      check("t6_mem", dmem[1], 64'd3);
      do_txn(1'b0, 3'b011, 64'd8, 64'd0, 5'd15, got, gf);
      check("t6_ld", got, 64'd3);

      // Random traffic
      for (int k = 0; k < 250; k++) begin
         st  = 1'($urandom_range(0, 1));
         f3  = 3'($urandom_range(0, 7));
         sel = int'($urandom_range(0, 9));
         a   = 64'($urandom_range(0, MEM_BYTES - 1));
         if (sel < 7) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
         else if (sel == 7) a = 64'(MEM_BYTES) + 64'($urandom_range(0, 64));
         else if (sel == 8) a = {32'($urandom), 32'($urandom)};
         do_txn(st, f3, a, {32'($urandom), 32'($urandom)}, 5'($urandom), got, gf);
      end

      // Final memory image
      for (int w = 0; w < MEM_DWS; w++) begin
         for (int b = 0; b < 8; b++) exp_dw[8*b +: 8] = ref_mem[8*w + b];
         check("final_mem", dmem[w], exp_dw);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
